// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_DEST = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  typedef logic [SEL_W-1:0] dest_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with load/drain handshake.
// DEMUX_STATS_EN adds a saturating per-slot drain counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned IW = 8
`ifdef DEMUX_STATS_EN
  ,
  parameter int unsigned CW = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [IW-1:0] load_data,
  output logic          valid,
  output logic [IW-1:0] data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CW-1:0] count
`endif
);

  slot_state_t state_q;
  slot_state_t state_d;
  logic [IW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A load in the same cycle as a drain wins: old word leaves, new word lands.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SLOT_FULL;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

`ifdef DEMUX_STATS_EN
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (drain && (count_q != '1)) begin
      count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;
`endif

endmodule

// File: rtl/demux_1to4_stream.sv
// Sequential 1-to-4 stream demultiplexer with per-destination registered slots.
// Optional drain counters on o_Count when DEMUX_STATS_EN is defined.
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int unsigned IW = 8
`ifdef DEMUX_STATS_EN
  ,
  parameter int unsigned CW = 16
`endif
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [SEL_W-1:0]      i_Select,
  input  logic [IW-1:0]         i_Data,
  output logic [NUM_DEST-1:0]   o_Valid,
  input  logic [NUM_DEST-1:0]   i_Ready,
  output logic [IW-1:0]         o_Data1,
  output logic [IW-1:0]         o_Data2,
  output logic [IW-1:0]         o_Data3,
  output logic [IW-1:0]         o_Data4
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_DEST*CW-1:0] o_Count
`endif
);

  dest_sel_t            sel;
  logic                 acc;
  logic [NUM_DEST-1:0]  load;
  logic [NUM_DEST-1:0]  drain;
  logic [IW-1:0]        slot_data [NUM_DEST];

  assign sel = i_Select;

  // Only the targeted slot gates acceptance; i_Ready feeds straight through.
  assign o_Ready = ~o_Valid[sel] | i_Ready[sel];
  assign acc     = i_Valid & o_Ready;

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    assign load[k]  = acc & (sel == dest_sel_t'(k));
    assign drain[k] = o_Valid[k] & i_Ready[k];

    demux_slot #(
      .IW (IW)
`ifdef DEMUX_STATS_EN
      ,
      .CW (CW)
`endif
    ) u_slot (
      .clk       (i_Clk),
      .rst_n     (i_Rst_n),
      .load      (load[k]),
      .drain     (drain[k]),
      .load_data (i_Data),
      .valid     (o_Valid[k]),
      .data      (slot_data[k])
`ifdef DEMUX_STATS_EN
      ,
      .count     (o_Count[k*CW +: CW])
`endif
    );
  end

  assign o_Data1 = slot_data[0];
  assign o_Data2 = slot_data[1];
  assign o_Data3 = slot_data[2];
  assign o_Data4 = slot_data[3];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream; stats checks when DEMUX_STATS_EN is defined.
module tb_demux_1to4_stream;

  localparam int unsigned IW = 8;
`ifdef DEMUX_STATS_EN
  localparam int unsigned CW = 4;
`endif

  logic          i_Clk;
  logic          i_Rst_n;
  logic          i_Valid;
  logic          o_Ready;
  logic [1:0]    i_Select;
  logic [IW-1:0] i_Data;
  logic [3:0]    o_Valid;
  logic [3:0]    i_Ready;
  logic [IW-1:0] o_Data1, o_Data2, o_Data3, o_Data4;
`ifdef DEMUX_STATS_EN
  logic [4*CW-1:0] o_Count;
`endif

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q [4][$];

  demux_1to4_stream #(
    .IW (IW)
`ifdef DEMUX_STATS_EN
    ,
    .CW (CW)
`endif
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Valid  (i_Valid),
    .o_Ready  (o_Ready),
    .i_Select (i_Select),
    .i_Data   (i_Data),
    .o_Valid  (o_Valid),
    .i_Ready  (i_Ready),
    .o_Data1  (o_Data1),
    .o_Data2  (o_Data2),
    .o_Data3  (o_Data3),
    .o_Data4  (o_Data4)
`ifdef DEMUX_STATS_EN
    ,
    .o_Count  (o_Count)
`endif
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] port_data(input int k);
    case (k)
      0:       return o_Data1;
      1:       return o_Data2;
      2:       return o_Data3;
      default: return o_Data4;
    endcase
  endfunction

  // Monitor: every drain handshake must deliver the oldest expected word of that slot.
  always @(negedge i_Clk) begin
    if (i_Rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (o_Valid[k] && i_Ready[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL drain_%0d: got unexpected word %0h expected none", k, port_data(k));
          end else begin
            logic [IW-1:0] e;
            e = exp_q[k].pop_front();
            if (port_data(k) !== e) begin
              errors++;
              $display("FAIL drain_%0d: got %0h expected %0h", k, port_data(k), e);
            end
          end
        end
      end
    end
  end

  // Called just after a rising edge; exp_rdy < 0 skips the o_Ready check.
  task automatic drive(input logic v, input logic [1:0] s, input logic [IW-1:0] d,
                       input logic [3:0] rdy, input int exp_rdy);
    i_Valid  = v;
    i_Select = s;
    i_Data   = d;
    i_Ready  = rdy;
    @(negedge i_Clk);
    if (exp_rdy >= 0) check("o_Ready", {31'd0, o_Ready}, exp_rdy);
    if (v && o_Ready) exp_q[s].push_back(d);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] rdy);
    drive(1'b0, 2'd0, 8'h00, rdy, -1);
  endtask

  initial begin
    logic [1:0]    rt_sel [4];
    logic [IW-1:0] rt_dat [4];
    rt_sel = '{2'd0, 2'd1, 2'd2, 2'd3};
    rt_dat = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held with a live input word present
    i_Rst_n  = 1'b0;
    i_Valid  = 1'b1;
    i_Select = 2'd1;
    i_Data   = 8'hA5;
    i_Ready  = 4'b1111;
    repeat (3) @(posedge i_Clk);
    #1;
    check("reset_valid", {28'd0, o_Valid}, 32'h0);
    check("reset_data", {o_Data4, o_Data3, o_Data2, o_Data1}, 32'h0);
`ifdef DEMUX_STATS_EN
    check("reset_count", {16'd0, o_Count}, 32'h0);
`endif
    i_Valid = 1'b0;
    i_Rst_n = 1'b1;
    @(negedge i_Clk);
    check("ready_after_reset", {31'd0, o_Ready}, 32'h1);
    @(posedge i_Clk);
    #1;

    // Basic routing, back-to-back, all consumers ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rt_sel[i], rt_dat[i], 4'b1111, 1);
      check("route_onehot", {28'd0, o_Valid}, 32'h1 << i);
      check("route_data", {24'd0, port_data(i)}, {24'd0, rt_dat[i]});
    end
    idle(4'b1111);
    check("route_empty", {28'd0, o_Valid}, 32'h0);

    // Backpressure on slot 2, then simultaneous drain and load
    drive(1'b1, 2'd2, 8'h5A, 4'b1011, 1);
    drive(1'b1, 2'd2, 8'h6B, 4'b1011, 0);
    drive(1'b1, 2'd2, 8'h6B, 4'b1011, 0);
    check("stall_valid", {28'd0, o_Valid}, 32'h4);
    check("stall_data", {24'd0, o_Data3}, 32'h5A);
    drive(1'b1, 2'd2, 8'h6B, 4'b1111, 1);
    check("swap_valid", {31'd0, o_Valid[2]}, 32'h1);
    check("swap_data", {24'd0, o_Data3}, 32'h6B);
    idle(4'b1111);
    check("bp_empty", {28'd0, o_Valid}, 32'h0);

    // No head-of-line blocking past a stalled slot 1
    drive(1'b1, 2'd1, 8'h31, 4'b0101, 1);
    drive(1'b1, 2'd3, 8'h77, 4'b0101, 1);
    check("hol_data4", {24'd0, o_Data4}, 32'h77);
    check("hol_valid", {28'd0, o_Valid}, 32'hA);
    drive(1'b1, 2'd1, 8'h99, 4'b0101, 0);
    drive(1'b1, 2'd0, 8'h0F, 4'b0101, 1);
    idle(4'b1111);
    idle(4'b1111);
    check("hol_empty", {28'd0, o_Valid}, 32'h0);

    // Asynchronous reset between edges discards held words
    drive(1'b1, 2'd0, 8'hC0, 4'b0110, 1);
    drive(1'b1, 2'd3, 8'hC3, 4'b0110, 1);
    check("pre_areset_valid", {28'd0, o_Valid}, 32'h9);
    i_Valid = 1'b0;
    #1;
    i_Rst_n = 1'b0;
    #1;
    check("areset_valid", {28'd0, o_Valid}, 32'h0);
    check("areset_data", {o_Data4, o_Data3, o_Data2, o_Data1}, 32'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    i_Rst_n = 1'b1;
    idle(4'b1111);
    check("post_areset_ready", {31'd0, o_Ready}, 32'h1);

`ifdef DEMUX_STATS_EN
    check("count_cleared", {16'd0, o_Count}, 32'h0);
    for (int i = 0; i < 17; i++) drive(1'b1, 2'd0, IW'(i), 4'b1111, 1);
    idle(4'b1111);
    idle(4'b1111);
    check("count_saturated", {16'd0, o_Count}, 32'h000F);
`endif

    idle(4'b1111);
    for (int k = 0; k < 4; k++) check("queue_empty", exp_q[k].size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
